// File: rtl/main_memory_read_controller.sv
// main_memory_read_controller: fetches one cache block from main memory, one word request at a time.
module main_memory_read_controller #(
  parameter int ADRES_BIT   = 32,
  parameter int KELIME_BIT  = 32,
  parameter int BLOK_KELIME = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [ADRES_BIT-1:0]              okuma_istek_adres_i,
  input  logic                              okuma_istek_gecerli_i,
  output logic [KELIME_BIT*BLOK_KELIME-1:0] okuma_veri_blok_o,
  output logic                              okuma_istek_hazir_o,
  output logic [ADRES_BIT-1:0]              bellek_adres_o,
  output logic                              bellek_istek_gecerli_o,
  input  logic                              bellek_istek_hazir_i,
  input  logic [KELIME_BIT-1:0]             bellek_veri_i,
  input  logic                              bellek_veri_gecerli_i
);
  localparam int WB = $clog2(KELIME_BIT / 8);
  localparam int OB = $clog2(BLOK_KELIME * KELIME_BIT / 8);
  localparam int CW = BLOK_KELIME > 1 ? $clog2(BLOK_KELIME) : 1;
  localparam logic [ADRES_BIT-1:0] HIZA = {ADRES_BIT{1'b1}} << OB;
  localparam logic [CW-1:0] SON = CW'(BLOK_KELIME - 1);
  typedef enum logic [1:0] {BOSTA, ISTEK, BEKLE, TAMAM} durum_t;
  durum_t durum, durum_n;
  logic [ADRES_BIT-1:0] taban;
  logic [CW-1:0] sayac;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) durum <= BOSTA;
    else durum <= durum_n;
  always_comb begin
    durum_n = durum;
    unique case (durum)
      BOSTA: if (okuma_istek_gecerli_i) durum_n = ISTEK;
      ISTEK: if (bellek_istek_hazir_i) durum_n = BEKLE;
      BEKLE: if (bellek_veri_gecerli_i) durum_n = sayac == SON ? TAMAM : ISTEK;
      default: durum_n = BOSTA;
    endcase
    bellek_istek_gecerli_o = durum == ISTEK;
    okuma_istek_hazir_o = durum == TAMAM;
    bellek_adres_o = taban + (ADRES_BIT'(sayac) << WB);
  end
  // the aligned base keeps the word offset inside the block, so no carry out of it
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      taban <= '0;
      sayac <= '0;
      okuma_veri_blok_o <= '0;
    end else begin
      if (durum == BOSTA && okuma_istek_gecerli_i) begin
        taban <= okuma_istek_adres_i & HIZA;
        sayac <= '0;
      end
      if (durum == BEKLE && bellek_veri_gecerli_i) begin
        okuma_veri_blok_o[sayac*KELIME_BIT +: KELIME_BIT] <= bellek_veri_i;
        if (sayac != SON) sayac <= sayac + 1'b1;
      end
    end
endmodule

// File: tb/tb_main_memory_read_controller.sv
// tb_main_memory_read_controller: directed scenarios checked against a transaction-level block-fetch model.
module tb_main_memory_read_controller;
  logic clk_i = 0;
  logic rst_i = 0;
  logic [31:0] okuma_istek_adres_i = 0;
  logic okuma_istek_gecerli_i = 0;
  logic [127:0] okuma_veri_blok_o;
  logic okuma_istek_hazir_o;
  logic [31:0] bellek_adres_o;
  logic bellek_istek_gecerli_o;
  logic bellek_istek_hazir_i = 0;
  logic [31:0] bellek_veri_i = 0;
  logic bellek_veri_gecerli_i = 0;

  main_memory_read_controller dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .okuma_istek_adres_i(okuma_istek_adres_i), .okuma_istek_gecerli_i(okuma_istek_gecerli_i),
    .okuma_veri_blok_o(okuma_veri_blok_o), .okuma_istek_hazir_o(okuma_istek_hazir_o),
    .bellek_adres_o(bellek_adres_o), .bellek_istek_gecerli_o(bellek_istek_gecerli_o),
    .bellek_istek_hazir_i(bellek_istek_hazir_i), .bellek_veri_i(bellek_veri_i),
    .bellek_veri_gecerli_i(bellek_veri_gecerli_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_q[$];
  int hz_q[$];
  logic [31:0] addr_q[$];

  // model: a fetch is busy until four words are collected; each word is one accepted address then one data beat
  logic m_busy = 0, m_acc = 0, m_done = 0;
  int m_got = 0;
  logic [31:0] m_base = 0;
  logic [127:0] m_blk = 0;

  // memory responder knobs
  int rdel[4];
  int vdel[4];
  logic spur = 0;
  logic [31:0] dbase = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk_i or negedge rst_i);
    if (!rst_i) begin
      m_busy = 0; m_acc = 0; m_done = 0; m_got = 0; m_base = 0; m_blk = 0;
    end else begin
      cyc++;
      if (m_done) m_done = 0;
      else if (!m_busy) begin
        if (okuma_istek_gecerli_i) begin
          m_busy = 1; m_acc = 0; m_got = 0;
          m_base = okuma_istek_adres_i & ~32'hF;
          acc_q.push_back(cyc);
        end
      end else if (!m_acc) begin
        if (bellek_istek_hazir_i) begin
          m_acc = 1;
          addr_q.push_back(m_base + 32'(4 * m_got));
        end
      end else if (bellek_veri_gecerli_i) begin
        m_blk[m_got*32 +: 32] = bellek_veri_i;
        m_got++;
        m_acc = 0;
        if (m_got == 4) begin m_busy = 0; m_done = 1; end
      end
    end
  end

  initial forever begin
    @(negedge clk_i);
    if (rst_i) begin
      chk("req_valid", 128'(bellek_istek_gecerli_o), 128'(m_busy && !m_acc));
      if (m_busy && !m_acc) chk("word_addr", 128'(bellek_adres_o), 128'(m_base + 32'(4 * m_got)));
      chk("ready", 128'(okuma_istek_hazir_o), 128'(m_done));
      chk("block", okuma_veri_blok_o, m_blk);
      if (okuma_istek_hazir_o) hz_q.push_back(cyc);
    end
  end

  initial begin
    int pend = 0, pw = 0, rcnt = 0, vcnt = 0;
    forever begin
      @(negedge clk_i);
      if (pend != 0) begin
        bellek_istek_hazir_i = spur;
        if (vcnt < vdel[pw]) begin
          vcnt++;
          bellek_veri_gecerli_i = spur;
          bellek_veri_i = 32'hDEADBEEF;
        end else begin
          bellek_veri_gecerli_i = 1;
          bellek_veri_i = dbase + 32'(pw);
          pend = 0; vcnt = 0;
        end
      end else if (bellek_istek_gecerli_o) begin
        bellek_veri_gecerli_i = spur;
        bellek_veri_i = 32'hDEADBEEF;
        if (rcnt < rdel[bellek_adres_o[3:2]]) begin
          rcnt++;
          bellek_istek_hazir_i = 0;
        end else begin
          bellek_istek_hazir_i = 1;
          pend = 1; pw = int'(bellek_adres_o[3:2]); rcnt = 0;
        end
      end else begin
        bellek_istek_hazir_i = spur;
        bellek_veri_gecerli_i = spur;
        bellek_veri_i = 32'hDEADBEEF;
      end
    end
  end

  task automatic start(input logic [31:0] a);
    okuma_istek_adres_i = a;
    okuma_istek_gecerli_i = 1;
    @(negedge clk_i);
    okuma_istek_gecerli_i = 0;
  endtask

  task automatic wait_hz(input int n);
    int s = hz_q.size();
    for (int i = 0; i < 300 && hz_q.size() < s + n; i++) @(negedge clk_i);
    if (hz_q.size() < s + n) begin
      checks++; errors++;
      $display("FAIL ready_timeout: got %0d pulses expected %0d", hz_q.size() - s, n);
    end
  endtask

  function automatic logic [127:0] addrs();
    return {addr_q[0], addr_q[1], addr_q[2], addr_q[3]};
  endfunction

  task automatic knobs_clear();
    for (int i = 0; i < 4; i++) begin rdel[i] = 0; vdel[i] = 0; end
  endtask

  initial begin
    int s;
    int a;
    knobs_clear();
    repeat (3) @(negedge clk_i);
    chk("rst_valid", 128'(bellek_istek_gecerli_o), 0);
    chk("rst_ready", 128'(okuma_istek_hazir_o), 0);
    chk("rst_addr", 128'(bellek_adres_o), 0);
    chk("rst_block", okuma_veri_blok_o, 0);
    rst_i = 1;
    @(negedge clk_i);

    // zero-wait fetch
    dbase = 32'hA0; addr_q.delete(); s = hz_q.size();
    start(32'h0000_1234);
    wait_hz(1);
    repeat (3) @(negedge clk_i);
    chk("zw_naddr", 128'(addr_q.size()), 4);
    chk("zw_addrs", addrs(), 128'h00001230_00001234_00001238_0000123C);
    chk("zw_block", okuma_veri_blok_o, 128'h000000A3_000000A2_000000A1_000000A0);
    chk("zw_latency", 128'(hz_q[$] - acc_q[$]), 8);
    chk("zw_pulses", 128'(hz_q.size() - s), 1);

    // stalls: 3 cycles of no-accept on word 1, data 2 cycles late on word 2
    knobs_clear(); rdel[1] = 3; vdel[2] = 2;
    addr_q.delete(); s = hz_q.size();
    start(32'h0000_1234);
    wait_hz(1);
    repeat (3) @(negedge clk_i);
    chk("st_addrs", addrs(), 128'h00001230_00001234_00001238_0000123C);
    chk("st_block", okuma_veri_blok_o, 128'h000000A3_000000A2_000000A1_000000A0);
    chk("st_latency", 128'(hz_q[$] - acc_q[$]), 13);
    chk("st_pulses", 128'(hz_q.size() - s), 1);

    // spurious handshakes and a request address change mid-fetch
    knobs_clear(); spur = 1; dbase = 32'hB0;
    repeat (3) @(negedge clk_i);
    addr_q.delete(); s = hz_q.size();
    start(32'h0000_1234);
    okuma_istek_adres_i = 32'hFFFF_FFF0;
    okuma_istek_gecerli_i = 1;
    repeat (3) @(negedge clk_i);
    okuma_istek_gecerli_i = 0;
    wait_hz(1);
    spur = 0;
    repeat (3) @(negedge clk_i);
    chk("ig_addrs", addrs(), 128'h00001230_00001234_00001238_0000123C);
    chk("ig_block", okuma_veri_blok_o, 128'h000000B3_000000B2_000000B1_000000B0);
    chk("ig_pulses", 128'(hz_q.size() - s), 1);

    // reset while waiting for word 2 data; that data then arrives late
    knobs_clear(); vdel[2] = 3; dbase = 32'hC0;
    s = hz_q.size();
    start(32'h0000_1234);
    for (int i = 0; i < 100 && !(m_got == 2 && m_acc); i++) @(negedge clk_i);
    chk("rs_reached", 128'(m_got == 2 && m_acc), 1);
    #2 rst_i = 0;
    #1;
    chk("rs_valid", 128'(bellek_istek_gecerli_o), 0);
    chk("rs_ready", 128'(okuma_istek_hazir_o), 0);
    chk("rs_addr", 128'(bellek_adres_o), 0);
    chk("rs_block", okuma_veri_blok_o, 0);
    repeat (2) @(negedge clk_i);
    rst_i = 1;
    repeat (6) @(negedge clk_i);
    chk("rs_late_block", okuma_veri_blok_o, 0);
    chk("rs_no_pulse", 128'(hz_q.size() - s), 0);
    knobs_clear(); dbase = 32'hD0; addr_q.delete();
    start(32'h0000_0040);
    wait_hz(1);
    repeat (3) @(negedge clk_i);
    chk("rs_addrs", addrs(), 128'h00000040_00000044_00000048_0000004C);
    chk("rs_block2", okuma_veri_blok_o, 128'h000000D3_000000D2_000000D1_000000D0);

    // back-to-back with the request held high
    dbase = 32'hE0; s = hz_q.size(); a = acc_q.size();
    okuma_istek_adres_i = 32'h0000_2000;
    okuma_istek_gecerli_i = 1;
    wait_hz(2);
    okuma_istek_gecerli_i = 0;
    repeat (3) @(negedge clk_i);
    chk("bb_accepts", 128'(acc_q.size() - a), 2);
    chk("bb_second_accept", 128'(acc_q[a+1] - hz_q[s]), 2);
    chk("bb_pulse_gap", 128'(hz_q[s+1] - hz_q[s]), 10);
    chk("bb_block", okuma_veri_blok_o, 128'h000000E3_000000E2_000000E1_000000E0);

    // top of the address space
    dbase = 32'h10; addr_q.delete();
    start(32'hFFFF_FFF4);
    wait_hz(1);
    repeat (3) @(negedge clk_i);
    chk("top_addrs", addrs(), 128'hFFFFFFF0_FFFFFFF4_FFFFFFF8_FFFFFFFC);
    chk("top_block", okuma_veri_blok_o, 128'h00000013_00000012_00000011_00000010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/main_memory_read_controller.md
MAIN_MEMORY_READ_CONTROLLER -- requirements
Module: main_memory_read_controller

Interface
REQ-001 The block SHALL have these parameters:
- ADRES_BIT, default 32, address width.
- KELIME_BIT, default 32, memory word width.
- BLOK_KELIME, default 4, words per cache block.
REQ-002 The block SHALL have these ports, with clock and reset first:

| Port | Dir | Width | Meaning |
|---|---|---|---|
| clk_i | in | 1 | single clock |
| rst_i | in | 1 | reset, asynchronous, active-low |
| okuma_istek_adres_i | in | ADRES_BIT | block read address from the instruction cache controller |
| okuma_istek_gecerli_i | in | 1 | block read request valid |
| okuma_veri_blok_o | out | KELIME_BIT*BLOK_KELIME | assembled block |
| okuma_istek_hazir_o | out | 1 | block ready, one-cycle pulse |
| bellek_adres_o | out | ADRES_BIT | word address to main memory |
| bellek_istek_gecerli_o | out | 1 | word read request valid |
| bellek_istek_hazir_i | in | 1 | memory accepts the word request |
| bellek_veri_i | in | KELIME_BIT | returned word |
| bellek_veri_gecerli_i | in | 1 | returned word valid |

Function
REQ-003 The block SHALL be the responder for block reads, serving one block at a time with at most one outstanding memory word request.
REQ-004 The state machine SHALL have four states: BOSTA, ISTEK, BEKLE, TAMAM.
REQ-005 In BOSTA, when okuma_istek_gecerli_i=1 at a rising edge, the block SHALL:
- latch the block-aligned address, okuma_istek_adres_i with bits [log2(BLOK_KELIME*KELIME_BIT/8)-1:0] forced to 0;
- clear the word counter;
- move to ISTEK.
REQ-006 In ISTEK:
- bellek_istek_gecerli_o SHALL be 1.
- bellek_adres_o SHALL equal the latched base plus counter*(KELIME_BIT/8).
- On bellek_istek_hazir_i=1 the block SHALL move to BEKLE; otherwise it SHALL hold the request, with address stable.
REQ-007 In BEKLE, on bellek_veri_gecerli_i=1:
- bellek_veri_i SHALL be written into okuma_veri_blok_o bits [counter*KELIME_BIT+KELIME_BIT-1 : counter*KELIME_BIT].
- If counter=BLOK_KELIME-1 the block SHALL move to TAMAM; otherwise it SHALL increment the counter and return to ISTEK.
REQ-008 In TAMAM, okuma_istek_hazir_o SHALL be 1 for exactly that one cycle, and the next state SHALL be BOSTA unconditionally.
REQ-009 bellek_istek_gecerli_o SHALL be 0 in every state other than ISTEK.
REQ-010 okuma_istek_hazir_o SHALL be 0 in every state other than TAMAM.
REQ-011 okuma_veri_blok_o SHALL hold its value outside BEKLE word captures, and SHALL stay stable in TAMAM and afterwards until the next capture.
REQ-012 Latency with zero-wait memory (hazir_i=1 in ISTEK, veri_gecerli_i=1 in the first BEKLE cycle): okuma_istek_hazir_o SHALL be high in the cycle beginning 2*BLOK_KELIME rising edges after the accepting edge, i.e. 8 edges for the defaults.
REQ-013 okuma_istek_gecerli_i and okuma_istek_adres_i SHALL be ignored outside BOSTA. Dropping the request mid-operation SHALL NOT abort the fetch, and address changes SHALL NOT affect it.
REQ-014 bellek_veri_gecerli_i SHALL be ignored outside BEKLE, including while the block is in ISTEK or BOSTA.
REQ-015 bellek_istek_hazir_i SHALL be ignored outside ISTEK.
REQ-016 Requests SHALL NOT be accepted in TAMAM. Earliest acceptance of the next request SHALL be the BOSTA cycle after TAMAM.
REQ-017 Address arithmetic SHALL be modulo 2^ADRES_BIT. The word offset SHALL never carry beyond the block, since the base is aligned.
REQ-018 The counter width SHALL be log2(BLOK_KELIME). Wrap-around SHALL NOT occur, because the state machine exits at BLOK_KELIME-1.

Reset
REQ-019 While rst_i=0, asynchronously, the block SHALL:
- force the state to BOSTA;
- clear the counter, the latched address and okuma_veri_blok_o to 0;
- drive okuma_istek_hazir_o=0, bellek_istek_gecerli_o=0 and bellek_adres_o=0.
REQ-020 Reset asserted mid-fetch SHALL abandon the fetch with no okuma_istek_hazir_o pulse, and any late bellek_veri_gecerli_i SHALL be ignored.
REQ-021 After rst_i rises, the first request SHALL be accepted at the first rising edge with okuma_istek_gecerli_i=1.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Zero-wait fetch: request at address 0x0000_1234; memory returns 0xA0,0xA1,0xA2,0xA3 for addresses 0x1230,0x1234,0x1238,0x123C. Required: bellek_adres_o sequence 0x1230,0x1234,0x1238,0x123C; okuma_veri_blok_o = {0xA3,0xA2,0xA1,0xA0}; hazir_o pulse 8 edges after acceptance, width 1.
- Stalls: bellek_istek_hazir_i held low 3 cycles on word 1 and bellek_veri_gecerli_i delayed 2 cycles on word 2. Required: address stable while stalled, same final block, exactly one hazir_o pulse.
- Ignored inputs: spurious bellek_veri_gecerli_i in BOSTA and ISTEK, and okuma_istek_adres_i changed to 0xFFFF_FFF0 mid-fetch. Required: block contents unaffected; addresses stay in the original block.
- Reset mid-fetch: rst_i=0 after word 1 captured. Required: outputs immediately 0, block = 0, no hazir_o pulse; a fresh request at 0x40 then completes normally.
- Back-to-back: okuma_istek_gecerli_i held high continuously. Required: TAMAM does not accept; second acceptance occurs in the BOSTA cycle after TAMAM; two hazir_o pulses separated by one idle cycle.
- Top address: request at 0xFFFF_FFF4. Required: words fetched from 0xFFFF_FFF0 to 0xFFFF_FFFC, with no wrap into 0x0.
